regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Write-back arbiter that drives the single register-file write port (RegWrite/addrW/dataW) from two producers.
- Producer 1: single-cycle ALU results. Producer 2: long-latency load/MDU responses.
- Long-latency results are buffered in a small FIFO and drained into idle write-port cycles.
- A per-register pending scoreboard lets decode stall on RAW/WAW hazards against outstanding long-latency ops.

Parameters:
XLEN, 32, data width of the write port
NREG, 32, number of architectural registers (x0 hard-wired zero)
FIFO_DEPTH, 2, long-latency result buffer entries (power of 2, >=2)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  reset, asynchronous, active-low
alu_valid  input  1  ALU result valid this cycle (always accepted)
alu_rd  input  5  ALU destination register
alu_data  input  XLEN  ALU result
ll_issue_valid  input  1  long-latency op issued this cycle
ll_issue_rd  input  5  destination of issued long-latency op
ll_resp_valid  input  1  long-latency response valid
ll_resp_ready  output  1  arbiter can accept response
ll_resp_rd  input  5  response destination register
ll_resp_data  input  XLEN  response data
RegWrite  output  1  register-file write enable (registered)
addrW  output  5  register-file write address (registered)
dataW  output  XLEN  register-file write data (registered)
pending_mask  output  NREG  bit r=1: long-latency write to xr outstanding
fifo_count  output  $clog2(FIFO_DEPTH)+1  occupied FIFO entries
err_waw  output  1  sticky protocol-violation flag

Behaviour:
- Reset (async assert, sync release):
  - RegWrite=0, addrW=0, dataW=0, pending_mask=0, fifo_count=0, err_waw=0.
  - FIFO pointers cleared; in-flight entries discarded.
- Response handshake:
  - ll_resp_ready = (fifo_count < FIFO_DEPTH); combinational from registered count only, no same-cycle pop bypass.
  - Transfer when ll_resp_valid && ll_resp_ready.
  - Accepted response with rd=0 is dropped (not enqueued).
  - Producer holds valid/rd/data stable until transfer.
- Arbitration, evaluated each cycle; ALU has strict priority:
  - alu_valid && alu_rd!=0: next-cycle port write = ALU result. FIFO does not pop.
  - Otherwise, if FIFO non-empty: pop head; next-cycle port write = head rd/data; clear pending_mask[head rd].
  - Otherwise: RegWrite<=0. addrW/dataW hold their last value.
- alu_valid with alu_rd=0: no write, and the cycle counts as idle, so the FIFO may drain.
- Latency:
  - ALU result appears on the port exactly 1 cycle after presentation.
  - FIFO entry appears 1 cycle after pop; minimum response-to-port latency is 2 cycles (enqueue, then pop).
- Simultaneous push and pop: both occur; fifo_count unchanged. Push into a full FIFO is impossible because ready=0.
- FIFO is in order, with wrap-around pointers (FIFO_DEPTH entries).
- Scoreboard:
  - ll_issue_valid && ll_issue_rd!=0 sets pending_mask[rd].
  - Pop of an entry clears pending_mask[its rd].
  - Same-cycle set and clear of the same bit: set wins.
- err_waw (sticky until reset) sets on any of:
  - ALU write to rd with pending_mask[rd]=1;
  - issue to rd with pending_mask[rd]=1 and no same-cycle clear;
  - accepted response with rd!=0 whose pending bit is 0.
- Decode must stall on pending_mask, so err_waw never fires in legal operation.
- Writes to x0 never assert RegWrite.

Test Plan:
- Reset, then alu_valid=1, rd=5, data=0xDEADBEEF -> next cycle RegWrite=1, addrW=5, dataW=0xDEADBEEF; following idle cycle RegWrite=0.
- Issue ll rd=7 -> pending_mask[7]=1. Response rd=7, data=0x1234 on an idle cycle -> ready=1, fifo_count=1, next cycle pop, then RegWrite/addrW=7/dataW=0x1234; pending_mask[7]=0 the cycle the write appears.
- ALU busy (rd=1..4) for 4 cycles while two responses (rd=8, rd=9) arrive:
  - FIFO fills to 2 and ready=0; a third response is held.
  - After the ALU stops, port writes x8 then x9 in order, then the held response is accepted.
- alu_valid with rd=0 while FIFO holds rd=10 -> FIFO pops that cycle; x0 is never written; RegWrite never asserts with addrW=0.
- ALU write to rd=7 while pending_mask[7]=1 -> err_waw=1 and stays 1. Response with rd=3 not pending -> err_waw remains 1.
- Assert rst_n=0 mid-drain (fifo_count=2, RegWrite=1) -> all outputs 0 immediately (async); after release, no stale entries are written.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus bundle: ALU result, long-latency issue/response handshake,
// register-file write port, pending scoreboard, FIFO level and error flag.
interface regfile_wb_arbiter_if #(
  parameter int XLEN       = 32,
  parameter int NREG       = 32,
  parameter int FIFO_DEPTH = 2
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            ll_issue_valid;
  logic [4:0]      ll_issue_rd;
  logic            ll_resp_valid;
  logic            ll_resp_ready;
  logic [4:0]      ll_resp_rd;
  logic [XLEN-1:0] ll_resp_data;
  logic            RegWrite;
  logic [4:0]      addrW;
  logic [XLEN-1:0] dataW;
  logic [NREG-1:0] pending_mask;
  logic [CW-1:0]   fifo_count;
  logic            err_waw;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ll_issue_valid, ll_issue_rd,
    output ll_resp_valid, ll_resp_rd, ll_resp_data,
    input  ll_resp_ready,
    input  RegWrite, addrW, dataW,
    input  pending_mask, fifo_count, err_waw
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ll_issue_valid, ll_issue_rd,
    input  ll_resp_valid, ll_resp_rd, ll_resp_data,
    output ll_resp_ready,
    output RegWrite, addrW, dataW,
    output pending_mask, fifo_count, err_waw
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: ALU has strict priority, long-latency
// responses queue in a FIFO and drain into idle write-port cycles.
// Ports: clk, rst_n (async, active-low), wb (slave side of the bundle).
module regfile_wb_arbiter #(
  parameter int XLEN       = 32,
  parameter int NREG       = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_wb_arbiter_if.slave  wb
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [4:0]      q_rd   [FIFO_DEPTH];
  logic [XLEN-1:0] q_data [FIFO_DEPTH];

  logic            we_q;
  logic [4:0]      addr_q;
  logic [XLEN-1:0] data_q;
  logic [NREG-1:0] pend_q;
  logic            err_q;

  logic            accept;
  logic            push;
  logic            alu_wr;
  logic            pop;
  logic            issue;
  logic [4:0]      head_rd;
  logic [XLEN-1:0] head_data;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;
  logic            err_hit;

  // Ready looks only at the registered level; a same-cycle pop
  // does not open a slot early.
  assign wb.ll_resp_ready = count < CW'(FIFO_DEPTH);

  assign accept    = wb.ll_resp_valid & wb.ll_resp_ready;
  assign push      = accept & (|wb.ll_resp_rd);
  assign alu_wr    = wb.alu_valid & (|wb.alu_rd);
  assign pop       = ~alu_wr & (count != '0);
  assign issue     = wb.ll_issue_valid & (|wb.ll_issue_rd);
  assign head_rd   = q_rd[rd_ptr];
  assign head_data = q_data[rd_ptr];

  assign set_mask = issue ? NREG'(1) << wb.ll_issue_rd : '0;
  assign clr_mask = pop ? NREG'(1) << head_rd : '0;

  // A re-issue to a register whose result is retiring this cycle is legal.
  assign err_hit =
      (alu_wr & pend_q[wb.alu_rd])
    | (issue & pend_q[wb.ll_issue_rd] & ~clr_mask[wb.ll_issue_rd])
    | (accept & (|wb.ll_resp_rd) & ~pend_q[wb.ll_resp_rd]);

  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[wr_ptr]   <= wb.ll_resp_rd;
      q_data[wr_ptr] <= wb.ll_resp_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      pend_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count  <= count + CW'(push) - CW'(pop);
      pend_q <= (pend_q & ~clr_mask) | set_mask;
      if (err_hit) err_q <= 1'b1;
      unique case (1'b1)
        alu_wr: begin
          we_q   <= 1'b1;
          addr_q <= wb.alu_rd;
          data_q <= wb.alu_data;
        end
        pop: begin
          we_q   <= 1'b1;
          addr_q <= head_rd;
          data_q <= head_data;
        end
        default: we_q <= 1'b0;
      endcase
    end
  end

  assign wb.RegWrite     = we_q;
  assign wb.addrW        = addr_q;
  assign wb.dataW        = data_q;
  assign wb.pending_mask = pend_q;
  assign wb.fifo_count   = count;
  assign wb.err_waw      = err_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed vector table,
// hand sequences for corner cases, and legal random traffic vs a queue model.
module tb_regfile_wb_arbiter;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int FD   = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(
    .XLEN(XLEN), .NREG(NREG), .FIFO_DEPTH(FD)
  ) bus ();

  regfile_wb_arbiter #(
    .XLEN(XLEN), .NREG(NREG), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wb(bus)
  );

  int checks = 0;
  int errors = 0;

  function automatic void chk(string nm, logic [63:0] act,
                              logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  bit          mpend[NREG];
  bit          m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  bit          m_err;

  function automatic void model_reset();
    mq.delete();
    foreach (mpend[i]) mpend[i] = 1'b0;
    m_we = 0; m_addr = '0; m_data = '0; m_err = 0;
  endfunction

  function automatic logic [31:0] pend_vec();
    logic [31:0] v = '0;
    foreach (mpend[i]) v[i] = mpend[i];
    return v;
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  function automatic void model_step();
    int   n     = mq.size();
    bit   alu_w = bus.alu_valid && bus.alu_rd != 0;
    bit   acc   = bus.ll_resp_valid && n < FD;
    bit   pop   = !alu_w && n > 0;
    ent_t h;
    h.rd = '0; h.d = '0;
    if (alu_w && mpend[bus.alu_rd]) m_err = 1;
    if (acc && bus.ll_resp_rd != 0 && !mpend[bus.ll_resp_rd]) m_err = 1;
    if (pop) h = mq.pop_front();
    if (bus.ll_issue_valid && bus.ll_issue_rd != 0 &&
        mpend[bus.ll_issue_rd] && !(pop && h.rd == bus.ll_issue_rd))
      m_err = 1;
    if (alu_w) begin
      m_we = 1; m_addr = bus.alu_rd; m_data = bus.alu_data;
    end else if (pop) begin
      m_we = 1; m_addr = h.rd; m_data = h.d;
      mpend[h.rd] = 0;
    end else begin
      m_we = 0;
    end
    if (acc && bus.ll_resp_rd != 0) begin
      ent_t e;
      e.rd = bus.ll_resp_rd; e.d = bus.ll_resp_data;
      mq.push_back(e);
    end
    if (bus.ll_issue_valid && bus.ll_issue_rd != 0)
      mpend[bus.ll_issue_rd] = 1;
  endfunction

  function automatic void check_all(string tag);
    chk({tag, "_we"},    bus.RegWrite, m_we);
    chk({tag, "_addr"},  bus.addrW, m_addr);
    chk({tag, "_data"},  bus.dataW, m_data);
    chk({tag, "_pend"},  bus.pending_mask, pend_vec());
    chk({tag, "_count"}, bus.fifo_count, mq.size());
    chk({tag, "_ready"}, bus.ll_resp_ready, mq.size() < FD);
    chk({tag, "_err"},   bus.err_waw, m_err);
    chk({tag, "_x0"},    bus.RegWrite && bus.addrW == 0, 0);
  endfunction

  task automatic drive(bit av, logic [4:0] ard, logic [31:0] ad,
                       bit iv, logic [4:0] ird,
                       bit rv, logic [4:0] rrd, logic [31:0] rdat);
    bus.alu_valid      = av;
    bus.alu_rd         = ard;
    bus.alu_data       = ad;
    bus.ll_issue_valid = iv;
    bus.ll_issue_rd    = ird;
    bus.ll_resp_valid  = rv;
    bus.ll_resp_rd     = rrd;
    bus.ll_resp_data   = rdat;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic cyc(string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          av;
    logic [4:0]  ard;
    logic [31:0] ad;
    bit          iv;
    logic [4:0]  ird;
    bit          rv;
    logic [4:0]  rrd;
    logic [31:0] rdat;
    bit          we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pm;
    int          cnt;
    bit          err;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mkv(
    bit av, logic [4:0] ard, logic [31:0] ad,
    bit iv, logic [4:0] ird,
    bit rv, logic [4:0] rrd, logic [31:0] rdat,
    bit we, logic [4:0] addr, logic [31:0] data,
    logic [31:0] pm, int cnt, bit err);
    vec_t v;
    v.av = av; v.ard = ard; v.ad = ad;
    v.iv = iv; v.ird = ird;
    v.rv = rv; v.rrd = rrd; v.rdat = rdat;
    v.we = we; v.addr = addr; v.data = data;
    v.pm = pm; v.cnt = cnt; v.err = err;
    return v;
  endfunction

  initial begin
    vecs[0]  = mkv(1,5,32'hDEADBEEF, 0,0, 0,0,0,
                   1,5,32'hDEADBEEF, 32'h0,   0,0);
    vecs[1]  = mkv(0,0,0, 0,0, 0,0,0,
                   0,5,32'hDEADBEEF, 32'h0,   0,0);
    vecs[2]  = mkv(0,0,0, 1,7, 0,0,0,
                   0,5,32'hDEADBEEF, 32'h80,  0,0);
    vecs[3]  = mkv(0,0,0, 0,0, 1,7,32'h1234,
                   0,5,32'hDEADBEEF, 32'h80,  1,0);
    vecs[4]  = mkv(0,0,0, 0,0, 0,0,0,
                   1,7,32'h1234,     32'h0,   0,0);
    vecs[5]  = mkv(0,0,0, 0,0, 0,0,0,
                   0,7,32'h1234,     32'h0,   0,0);
    vecs[6]  = mkv(0,0,0, 1,8, 0,0,0,
                   0,7,32'h1234,     32'h100, 0,0);
    vecs[7]  = mkv(0,0,0, 1,9, 0,0,0,
                   0,7,32'h1234,     32'h300, 0,0);
    vecs[8]  = mkv(1,1,32'h1, 1,10, 1,8,32'h88,
                   1,1,32'h1,        32'h700, 1,0);
    vecs[9]  = mkv(1,2,32'h2, 0,0, 1,9,32'h99,
                   1,2,32'h2,        32'h700, 2,0);
    vecs[10] = mkv(1,3,32'h3, 0,0, 1,10,32'hAA,
                   1,3,32'h3,        32'h700, 2,0);
    vecs[11] = mkv(1,4,32'h4, 0,0, 1,10,32'hAA,
                   1,4,32'h4,        32'h700, 2,0);
    vecs[12] = mkv(0,0,0, 0,0, 1,10,32'hAA,
                   1,8,32'h88,       32'h600, 1,0);
    vecs[13] = mkv(0,0,0, 0,0, 1,10,32'hAA,
                   1,9,32'h99,       32'h400, 1,0);
    vecs[14] = mkv(0,0,0, 0,0, 0,0,0,
                   1,10,32'hAA,      32'h0,   0,0);
    vecs[15] = mkv(0,0,0, 0,0, 0,0,0,
                   0,10,32'hAA,      32'h0,   0,0);
  end

  // ---------------- main sequence ----------------
  bit          hold;
  bit          acc;
  bit          av, iv;
  logic [4:0]  ard, ird, rrd;
  logic [31:0] ad, rdat;
  logic [4:0]  outst[$];

  initial begin
    idle();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;

    // directed table
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].av, vecs[i].ard, vecs[i].ad,
            vecs[i].iv, vecs[i].ird,
            vecs[i].rv, vecs[i].rrd, vecs[i].rdat);
      model_step();
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_we", i),    bus.RegWrite, vecs[i].we);
      chk($sformatf("vec%0d_addr", i),  bus.addrW, vecs[i].addr);
      chk($sformatf("vec%0d_data", i),  bus.dataW, vecs[i].data);
      chk($sformatf("vec%0d_pend", i),  bus.pending_mask, vecs[i].pm);
      chk($sformatf("vec%0d_count", i), bus.fifo_count, vecs[i].cnt);
      chk($sformatf("vec%0d_ready", i), bus.ll_resp_ready,
          vecs[i].cnt < FD);
      chk($sformatf("vec%0d_err", i),   bus.err_waw, vecs[i].err);
    end

    // x0 ALU slot lets the FIFO drain
    drive(0, 0, 0, 1, 10, 0, 0, 0);          cyc("x0_issue");
    drive(0, 0, 0, 0, 0, 1, 10, 32'h10A);    cyc("x0_resp");
    chk("x0_fill", bus.fifo_count, 1);
    drive(1, 0, 32'hBAD, 0, 0, 0, 0, 0);     cyc("x0_alu");
    chk("x0_drain_we",   bus.RegWrite, 1);
    chk("x0_drain_addr", bus.addrW, 10);
    chk("x0_drain_data", bus.dataW, 32'h10A);
    idle();                                  cyc("x0_idle");

    // legal random traffic
    hold = 0;
    rrd = '0;
    rdat = '0;
    for (int c = 0; c < 600; c++) begin
      av  = bit'($urandom_range(0, 1));
      ard = 5'($urandom_range(0, 31));
      if (mpend[ard]) ard = '0;
      ad  = $urandom;
      iv  = ($urandom_range(0, 3) == 0);
      ird = 5'($urandom_range(1, 31));
      if (mpend[ird]) iv = 0;
      if (!hold) begin
        if (outst.size() > 0 && $urandom_range(0, 2) == 0) begin
          hold = 1; rrd = outst.pop_front(); rdat = $urandom;
        end else if ($urandom_range(0, 15) == 0) begin
          hold = 1; rrd = '0; rdat = $urandom;
        end
      end
      acc = hold && mq.size() < FD;
      drive(av, ard, ad, iv, ird, hold, rrd, rdat);
      cyc("rand");
      if (iv) outst.push_back(ird);
      if (acc) hold = 0;
    end
    chk("rand_no_err", bus.err_waw, 0);

    // drain outstanding work before the error sequence
    idle();
    while (outst.size() > 0 || hold) begin
      if (!hold) begin
        hold = 1; rrd = outst.pop_front(); rdat = $urandom;
      end
      acc = mq.size() < FD;
      drive(0, 0, 0, 0, 0, 1, rrd, rdat);
      cyc("flush");
      if (acc) hold = 0;
    end
    idle();
    repeat (3) cyc("flush_idle");
    chk("flush_empty", bus.fifo_count, 0);
    chk("flush_pend",  bus.pending_mask, 0);

    // protocol violations set the sticky error
    drive(0, 0, 0, 1, 7, 0, 0, 0);           cyc("err_issue");
    chk("err_pre", bus.err_waw, 0);
    drive(1, 7, 32'h77, 0, 0, 0, 0, 0);      cyc("err_alu");
    chk("err_alu_waw", bus.err_waw, 1);
    drive(0, 0, 0, 0, 0, 1, 3, 32'h33);      cyc("err_resp");
    chk("err_sticky", bus.err_waw, 1);
    idle();
    repeat (3) cyc("err_idle");
    chk("err_sticky2", bus.err_waw, 1);

    // async reset in the middle of a drain
    drive(0, 0, 0, 1, 11, 0, 0, 0);          cyc("rst_i11");
    drive(0, 0, 0, 1, 12, 0, 0, 0);          cyc("rst_i12");
    drive(1, 1, 32'h1, 0, 0, 1, 11, 32'hB1); cyc("rst_f1");
    drive(1, 2, 32'h2, 0, 0, 1, 12, 32'hB2); cyc("rst_f2");
    chk("rst_pre_count", bus.fifo_count, 2);
    chk("rst_pre_we",    bus.RegWrite, 1);
    idle();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rst_async");
    chk("rst_async_err", bus.err_waw, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc("rst_post");
      chk("rst_post_nowrite", bus.RegWrite, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
